// File: rtl/dp_bus_regfile.sv
// Shared-bus register file with a PC-style address-pair incrementer and a handshaked memory
// sequencer with timeout. Optional multi-driver detection is enabled by BUS_CONFLICT_CHECK_EN.
module dp_bus_regfile #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NREGS   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREGS-1:0]         i_drv_en,
    input  logic                     i_mdr_drv,
    input  logic [NREGS-1:0]         i_ld_en,
    input  logic [$clog2(NREGS)-1:0] i_lo_sel,
    input  logic [$clog2(NREGS)-1:0] i_hi_sel,
    input  logic                     i_inc_en,
    input  logic                     i_mem_req,
    input  logic                     i_mem_we,
    output logic                     o_mem_valid,
    output logic                     o_mem_wr,
    output logic [2*DATA_W-1:0]      o_mem_addr,
    output logic [DATA_W-1:0]        o_mem_wdata,
    input  logic [DATA_W-1:0]        i_mem_rdata,
    input  logic                     i_mem_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_timeout,
    output logic [DATA_W-1:0]        o_data_bus,
    output logic                     o_bus_err
);
    localparam int unsigned SEL_W    = $clog2(NREGS);
    localparam int unsigned PAIR_W   = 2 * DATA_W;
    localparam logic [7:0]  TO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    logic [DATA_W-1:0] r_regs     [NREGS];
    logic [DATA_W-1:0] w_regs_nxt [NREGS];
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] w_bus;
    logic [DATA_W-1:0] w_bus_or;
    logic              w_bus_any;
    logic [PAIR_W-1:0] w_pair_inc;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
    logic              w_latch;
    logic              w_mdr_ld;
    logic              w_to_pulse;
    logic              r_timeout;
    logic              r_mem_wr;
    logic [PAIR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    // Data bus: wired-OR of all drivers, precharged to all ones when nobody drives.
    always_comb begin
        w_bus_or  = i_mdr_drv ? r_mdr : '0;
        w_bus_any = i_mdr_drv;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (i_drv_en[i]) begin
                w_bus_or  = w_bus_or | r_regs[i];
                w_bus_any = 1'b1;
            end
        end
    end

`ifdef BUS_CONFLICT_CHECK_EN
    localparam int unsigned CNT_W = $clog2(NREGS + 2);

    logic [CNT_W-1:0] w_drv_cnt;
    logic             w_conflict;
    logic             r_bus_err;

    always_comb begin
        w_drv_cnt = CNT_W'(i_mdr_drv);
        for (int unsigned i = 0; i < NREGS; i++) begin
            w_drv_cnt = w_drv_cnt + CNT_W'(i_drv_en[i]);
        end
    end

    assign w_conflict = (w_drv_cnt > CNT_W'(1));
    assign w_bus      = w_conflict ? '0 : (w_bus_any ? w_bus_or : '1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bus_err <= 1'b0;
        end else if (w_conflict) begin
            r_bus_err <= 1'b1;
        end
    end

    assign o_bus_err = r_bus_err;
`else
    assign w_bus     = w_bus_any ? w_bus_or : '1;
    assign o_bus_err = 1'b0;
`endif

    assign o_data_bus = w_bus;
    assign w_pair_inc = {r_regs[i_hi_sel], r_regs[i_lo_sel]} + PAIR_W'(1);

    // Increment first, then a load on the same register overrides it byte-wise.
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            w_regs_nxt[i] = r_regs[i];
            if (i_inc_en) begin
                if (i_lo_sel == i_hi_sel) begin
                    if (i_lo_sel == SEL_W'(i)) begin
                        w_regs_nxt[i] = r_regs[i] + DATA_W'(1);
                    end
                end else if (i_lo_sel == SEL_W'(i)) begin
                    w_regs_nxt[i] = w_pair_inc[DATA_W-1:0];
                end else if (i_hi_sel == SEL_W'(i)) begin
                    w_regs_nxt[i] = w_pair_inc[PAIR_W-1:DATA_W];
                end
            end
            if (i_ld_en[i]) begin
                w_regs_nxt[i] = w_bus;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= w_regs_nxt[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_mdr_ld    = 1'b0;
        w_to_pulse  = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_mem_req) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StReq;
                end
            end
            StReq: begin
                // Completion takes priority over an expiring wait counter.
                if (i_mem_ready) begin
                    w_mdr_ld    = ~r_mem_wr;
                    w_state_nxt = StDone;
                end else if (r_cnt == TO_LIMIT) begin
                    w_to_pulse  = 1'b1;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mdr       <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_to_pulse;
            if (w_latch) begin
                r_mem_wr    <= i_mem_we;
                r_mem_addr  <= {r_regs[i_hi_sel], r_regs[i_lo_sel]};
                r_mem_wdata <= w_bus;
            end
            if (w_mdr_ld) begin
                r_mdr <= i_mem_rdata;
            end
        end
    end

    assign o_mem_valid = (r_state == StReq);
    assign o_mem_wr    = r_mem_wr & o_mem_valid;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = (r_state != StIdle);
    assign o_done      = (r_state == StDone);
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_dp_bus_regfile.sv
// Self-checking bench for dp_bus_regfile: directed steps plus randomized traffic against an
// arithmetic reference model of the register file, bus and memory handshake.
module tb_dp_bus_regfile;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  drv_en;
    logic        mdr_drv;
    logic [7:0]  ld_en;
    logic [2:0]  lo_sel;
    logic [2:0]  hi_sel;
    logic        inc_en;
    logic        mem_req;
    logic        mem_we;
    logic        mem_valid;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  data_bus;
    logic        bus_err;

    int          n_checks = 0;
    int          n_errs   = 0;

    logic [7:0]  m_regs [8];
    logic [7:0]  m_mdr;
    logic        m_err;

    always #5 clk = ~clk;

    dp_bus_regfile #(.DATA_W(8), .NREGS(8), .TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_drv_en    (drv_en),
        .i_mdr_drv   (mdr_drv),
        .i_ld_en     (ld_en),
        .i_lo_sel    (lo_sel),
        .i_hi_sel    (hi_sel),
        .i_inc_en    (inc_en),
        .i_mem_req   (mem_req),
        .i_mem_we    (mem_we),
        .o_mem_valid (mem_valid),
        .o_mem_wr    (mem_wr),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_timeout   (timeout),
        .o_data_bus  (data_bus),
        .o_bus_err   (bus_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=no finish required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_bus();
        logic [7:0] v;
        int         n;
        v = mdr_drv ? m_mdr : 8'h00;
        n = $countones(drv_en) + (mdr_drv ? 1 : 0);
        for (int i = 0; i < 8; i++) begin
            if (drv_en[i]) v = v | m_regs[i];
        end
        if (n == 0) return 8'hFF;
`ifdef BUS_CONFLICT_CHECK_EN
        if (n > 1) return 8'h00;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_mdr = 8'h00;
        m_err = 1'b0;
    endtask

    task automatic idle();
        drv_en  = 8'h00;
        mdr_drv = 1'b0;
        ld_en   = 8'h00;
        inc_en  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        mem_ready = 1'b0;
    endtask

    // One clock with current inputs: check the bus, advance the model, then check bus_err.
    task automatic cycle(input string tag);
        logic [7:0] b;
        logic [7:0] nx [8];
        int         p;
        #1;
        b = model_bus();
        chk({tag, "_bus"}, 32'(data_bus), 32'(b));
        nx = m_regs;
        if (inc_en) begin
            if (lo_sel == hi_sel) begin
                nx[lo_sel] = m_regs[lo_sel] + 8'd1;
            end else begin
                p = (int'(m_regs[hi_sel]) * 256 + int'(m_regs[lo_sel]) + 1) % 65536;
                nx[lo_sel] = p[7:0];
                nx[hi_sel] = p[15:8];
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (ld_en[i]) nx[i] = b;
        end
`ifdef BUS_CONFLICT_CHECK_EN
        if ($countones(drv_en) + (mdr_drv ? 1 : 0) > 1) m_err = 1'b1;
`endif
        @(posedge clk);
        #1;
        m_regs = nx;
        chk({tag, "_bus_err"}, 32'(bus_err), 32'(m_err));
    endtask

    task automatic check_reg(input int i);
        idle();
        drv_en = 8'd1 << i;
        cycle($sformatf("reg%0d", i));
        idle();
    endtask

    task automatic check_mdr();
        idle();
        mdr_drv = 1'b1;
        cycle("mdr");
        idle();
    endtask

    // rdy_at: REQ cycle index on which mem_ready is raised; > TO means never.
    task automatic access(input logic we, input int rdy_at, input logic [7:0] rd,
                          input logic [7:0] drv, input logic inc, input string tag);
        logic [15:0] ea;
        logic [7:0]  ew;
        logic        ok;
        int          nv;
        idle();
        drv_en  = drv;
        inc_en  = inc;
        mem_req = 1'b1;
        mem_we  = we;
        ea = {m_regs[hi_sel], m_regs[lo_sel]};
        ew = model_bus();
        cycle({tag, "_req"});
        idle();
        ok = (rdy_at <= TO);
        nv = ok ? rdy_at + 1 : TO + 1;
        for (int k = 0; k < nv; k++) begin
            mem_ready = (k == rdy_at);
            mem_rdata = (k == rdy_at) ? rd : 8'($urandom);
            #1;
            chk({tag, "_valid"}, 32'(mem_valid), 32'd1);
            chk({tag, "_addr"},  32'(mem_addr),  32'(ea));
            chk({tag, "_wdata"}, 32'(mem_wdata), 32'(ew));
            chk({tag, "_wr"},    32'(mem_wr),    32'(we));
            chk({tag, "_busy"},  32'(busy),      32'd1);
            chk({tag, "_nodone"}, 32'(done),     32'd0);
            cycle({tag, "_wait"});
        end
        mem_ready = 1'b0;
        if (ok && !we) m_mdr = rd;
        #1;
        if (ok) begin
            chk({tag, "_done"},     32'(done),      32'd1);
            chk({tag, "_dn_valid"}, 32'(mem_valid), 32'd0);
            chk({tag, "_dn_busy"},  32'(busy),      32'd1);
            chk({tag, "_dn_to"},    32'(timeout),   32'd0);
            cycle({tag, "_dn"});
            chk({tag, "_done_end"}, 32'(done), 32'd0);
            chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        end else begin
            chk({tag, "_timeout"},  32'(timeout),   32'd1);
            chk({tag, "_to_busy"},  32'(busy),      32'd0);
            chk({tag, "_to_valid"}, 32'(mem_valid), 32'd0);
            chk({tag, "_to_done"},  32'(done),      32'd0);
            cycle({tag, "_to"});
            chk({tag, "_to_end"}, 32'(timeout), 32'd0);
        end
    endtask

    // Arbitrary values reach a register only through a memory read into the MDR.
    task automatic set_reg(input int i, input logic [7:0] v);
        access(1'b0, 0, v, 8'h00, 1'b0, "setreg");
        idle();
        mdr_drv = 1'b1;
        ld_en   = 8'd1 << i;
        cycle("setreg_ld");
        idle();
    endtask

    initial begin
        rst_n     = 1'b0;
        lo_sel    = 3'd0;
        hi_sel    = 3'd1;
        mem_rdata = 8'h00;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   32'(mem_valid), 32'd0);
        chk("rst_wr",      32'(mem_wr),    32'd0);
        chk("rst_busy",    32'(busy),      32'd0);
        chk("rst_done",    32'(done),      32'd0);
        chk("rst_timeout", 32'(timeout),   32'd0);
        chk("rst_bus_err", 32'(bus_err),   32'd0);
        chk("rst_addr",    32'(mem_addr),  32'd0);
        chk("rst_wdata",   32'(mem_wdata), 32'd0);
        chk("rst_bus",     32'(data_bus),  32'hFF);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) check_reg(i);
        check_mdr();

        // Precharged bus loads 0xFF, then a register-to-register move.
        idle(); ld_en = 8'h08; cycle("t1_ld3");
        check_reg(3);
        idle(); drv_en = 8'h08; ld_en = 8'h20; cycle("t1_mv");
        check_reg(5);
        idle(); drv_en = 8'h20; ld_en = 8'h20; cycle("t1_self");
        check_reg(5);

        // Pair increment with carry from low into high byte.
        lo_sel = 3'd0; hi_sel = 3'd1;
        idle(); ld_en = 8'h01; cycle("t2_ld0");
        set_reg(1, 8'h12);
        idle(); inc_en = 1'b1; cycle("t2_inc");
        check_reg(0);
        check_reg(1);

        // Read at 0x1300 with ready on the third REQ cycle.
        access(1'b0, 2, 8'hA5, 8'h00, 1'b0, "t3_rd");
        check_mdr();

        // Pair wrap 0xFFFF -> 0x0000 and single-register increment.
        idle(); ld_en = 8'h03; cycle("t2_ldff");
        idle(); inc_en = 1'b1; cycle("t2_wrap");
        check_reg(0);
        check_reg(1);
        lo_sel = 3'd5; hi_sel = 3'd5;
        idle(); inc_en = 1'b1; cycle("t2_same");
        check_reg(5);
        lo_sel = 3'd0; hi_sel = 3'd1;

        // Write never acknowledged; latched address is the pre-increment value.
        access(1'b1, 1000, 8'h00, 8'h08, 1'b1, "t4_wr");
        check_mdr();

        // Asynchronous reset in the middle of REQ.
        idle(); mem_req = 1'b1; cycle("t5_req");
        idle();
        #1;
        chk("t5_valid_pre", 32'(mem_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_valid_rst", 32'(mem_valid), 32'd0);
        chk("t5_busy_rst",  32'(busy),      32'd0);
        chk("t5_addr_rst",  32'(mem_addr),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) check_reg(i);
        check_mdr();
        access(1'b0, 1, 8'h3C, 8'h00, 1'b0, "t5_rd");
        check_mdr();

        // Randomized traffic: single drivers only, so conflicts stay confined to the last step.
        for (int it = 0; it < 250; it++) begin
            logic [7:0] d;
            idle();
            lo_sel = 3'($urandom);
            hi_sel = 3'($urandom);
            d = ($urandom_range(0, 2) == 0) ? 8'h00 : (8'd1 << $urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) begin
                access(1'($urandom), int'($urandom_range(0, 18)), 8'($urandom), d,
                       1'($urandom), "rnd_acc");
            end else begin
                drv_en  = d;
                mdr_drv = (d == 8'h00) && ($urandom_range(0, 3) == 0);
                ld_en   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
                inc_en  = 1'($urandom);
                cycle("rnd");
            end
        end
        for (int i = 0; i < 8; i++) check_reg(i);
        check_mdr();

        // Two drivers at once.
        set_reg(0, 8'h5A);
        set_reg(1, 8'h0F);
        idle(); drv_en = 8'h03; ld_en = 8'h10; cycle("t6_conf");
        check_reg(4);
        idle(); cycle("t6_sticky");
        check_reg(0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
